fec_chain_sequencer: RTL and testbench
======================================

# fec_chain_sequencer

Frame-level sequencer for the FEC transmit chain. On an upstream request it pulls `FRAME_LEN` words from the shared input buffer and walks each word through the encoder, then the modulator, using four-phase req/ack handshakes on each stage. It sits between the system controller and the encoder/modulator datapath. It reports frame completion or a per-stage timeout back upstream over its own four-phase handshake.

## Interface
Parameters:
- `FRAME_LEN`, default 8: words per frame; must be ≥1.
- `TIMEOUT_CYC`, default 255: maximum cycles spent in any stage wait state; must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: block enable; low aborts any frame in progress.
- `req` in 1: upstream frame request (four-phase).
- `ack` out 1: upstream acknowledge (four-phase).
- `err` out 1: frame aborted by timeout; valid while `ack`=1.
- `buff_empty` in 1: input buffer has no word.
- `rd_en_buff` out 1: buffer read strobe, one cycle per word.
- `req_encoder` out 1: encoder request.
- `ack_encoder` in 1: encoder acknowledge.
- `en_encoder` out 1: encoder enable.
- `req_modulator` out 1: modulator request.
- `ack_modulator` in 1: modulator acknowledge.
- `en_modulator` out 1: modulator enable.
- `words_done` out `$clog2(FRAME_LEN+1)`: words fully processed in the current or last frame.

## Operation
- States: IDLE, FETCH, ENC_REQ, ENC_REL, MOD_REQ, MOD_REL, DONE, ERR.
- IDLE → FETCH when `en && req`. `words_done` is cleared on this transition.
- FETCH: `rd_en_buff` = `!buff_empty`; this is the only Mealy output. If `!buff_empty`, go to ENC_REQ. Otherwise stay in FETCH indefinitely with no timeout.
- ENC_REQ: `req_encoder`=`en_encoder`=1. Go to ENC_REL when `ack_encoder`=1.
- ENC_REL: `req_encoder`=0, `en_encoder`=1. Go to MOD_REQ when `ack_encoder`=0.
- MOD_REQ and MOD_REL behave the same as the encoder pair, using the modulator signals.
- On leaving MOD_REL, `words_done` increments. If the new value equals `FRAME_LEN`, go to DONE; otherwise go to FETCH.
- DONE: `ack`=1, `err`=0. Return to IDLE when `req`=0.
- ERR: `ack`=1, `err`=1. Return to IDLE when `req`=0. `err` clears on that transition.
- Timeout: a wait timer runs only in ENC_REQ, ENC_REL, MOD_REQ and MOD_REL.
  - It is cleared on every state change.
  - If the timer equals `TIMEOUT_CYC-1` and the awaited ack level is absent, the next state is ERR.
  - Width is `$clog2(TIMEOUT_CYC+1)`; the timer never wraps.
- Abort: `en`=0 in any state other than IDLE, DONE or ERR forces IDLE on the next edge.
  - All stage req/en outputs drop.
  - `words_done` holds its value.
  - No `ack` is issued; upstream must drop `req` and re-request.
- `en`=0 in DONE or ERR has no effect; the upstream handshake completes normally.
- `req` falling while the frame is running is ignored until DONE or ERR.

## Timing
- Reset state: IDLE. Every output is 0 in reset and IDLE, including `words_done`=0 and the timer at 0.
- All outputs except `rd_en_buff` are decoded from registered state, so they change one cycle after the causing input is sampled.
- With zero-latency stages (acks following req combinationally) and a non-empty buffer:
  - Each word costs exactly 5 cycles (FETCH, ENC_REQ, ENC_REL, MOD_REQ, MOD_REL).
  - If `req` is sampled at edge 0, FETCH starts at cycle 1 and `ack` rises at cycle 1+5·`FRAME_LEN` (cycle 41 for the defaults).
- `rd_en_buff` pulses exactly once per word, in the cycle that leaves FETCH.
- Back-to-back frames: with `req` low for 1 cycle after `ack`, the earliest restart is IDLE for one cycle, then FETCH.
- Worst case from entering a stage wait state to entering ERR: `TIMEOUT_CYC` cycles.

## Test plan
- Nominal frame: FRAME_LEN=8, TIMEOUT_CYC=255, combinational acks, buffer never empty, `req` at cycle 0 → `ack`=1 at cycle 41, `err`=0, `words_done`=8, exactly 8 `rd_en_buff` pulses, 8 encoder and 8 modulator handshakes strictly alternating.
- Empty stall: assert `buff_empty` for cycles 1–20 → FETCH holds with `rd_en_buff`=0 and no timeout → `ack` at cycle 61.
- Encoder timeout: TIMEOUT_CYC=16, `ack_encoder` held 0 on word 3 → ERR entered exactly 16 cycles after ENC_REQ entry, `err`=`ack`=1, `words_done`=2, `req_encoder`=0; dropping `req` → IDLE with `err`=0.
- Stuck-high release: `ack_modulator` held 1 after MOD_REQ → ERR from MOD_REL after `TIMEOUT_CYC` cycles.
- Abort: drop `en` mid-ENC_REQ of word 5 → next cycle IDLE, all req/en outputs 0, `ack`=0, `words_done`=4; re-request → `words_done` cleared and a full frame completes.
- Async reset mid-MOD_REQ: assert `rst_n`=0 off-edge → all outputs 0 immediately; after release, the block idles until a new `en && req`.

Source files
------------

// File: rtl/fec_chain_sequencer.sv
// Frame sequencer for the FEC transmit chain: fetches FRAME_LEN words and walks each
// through encoder then modulator with four-phase handshakes, reporting done/timeout upstream.
module fec_chain_sequencer #(
  parameter int FRAME_LEN   = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               req,
  output logic                               ack,
  output logic                               err,
  input  logic                               buff_empty,
  output logic                               rd_en_buff,
  output logic                               req_encoder,
  input  logic                               ack_encoder,
  output logic                               en_encoder,
  output logic                               req_modulator,
  input  logic                               ack_modulator,
  output logic                               en_modulator,
  output logic [$clog2(FRAME_LEN+1)-1:0]     words_done
);

  localparam int WD_W = $clog2(FRAME_LEN + 1);
  localparam int TM_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TM_W-1:0] TMO_LAST  = TM_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WORD_LAST = WD_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ENC_REQ, S_ENC_REL, S_MOD_REQ, S_MOD_REL, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [TM_W-1:0]   timer;
  logic              waiting;
  logic              running;
  logic              timeout;

  assign waiting = (state == S_ENC_REQ) || (state == S_ENC_REL) ||
                   (state == S_MOD_REQ) || (state == S_MOD_REL);
  assign running = waiting || (state == S_FETCH);
  assign timeout = (timer == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      words_done <= '0;
    end else begin
      state <= state_nxt;
      // The timer measures dwell in one wait state, so any transition restarts it.
      if (state_nxt != state)
        timer <= '0;
      else if (waiting && !timeout)
        timer <= timer + 1'b1;
      if (state == S_IDLE && state_nxt == S_FETCH)
        words_done <= '0;
      else if (state == S_MOD_REL && (state_nxt == S_FETCH || state_nxt == S_DONE))
        words_done <= words_done + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (en && req) state_nxt = S_FETCH;
      S_FETCH:   if (!buff_empty) state_nxt = S_ENC_REQ;
      S_ENC_REQ: if (ack_encoder) state_nxt = S_ENC_REL;
                 else if (timeout) state_nxt = S_ERR;
      S_ENC_REL: if (!ack_encoder) state_nxt = S_MOD_REQ;
                 else if (timeout) state_nxt = S_ERR;
      S_MOD_REQ: if (ack_modulator) state_nxt = S_MOD_REL;
                 else if (timeout) state_nxt = S_ERR;
      S_MOD_REL: if (!ack_modulator) state_nxt = (words_done == WORD_LAST) ? S_DONE : S_FETCH;
                 else if (timeout) state_nxt = S_ERR;
      S_DONE:    if (!req) state_nxt = S_IDLE;
      S_ERR:     if (!req) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    // Losing enable abandons the frame silently; DONE/ERR still finish their handshake.
    if (!en && running)
      state_nxt = S_IDLE;
  end

  always_comb begin
    ack           = 1'b0;
    err           = 1'b0;
    req_encoder   = 1'b0;
    en_encoder    = 1'b0;
    req_modulator = 1'b0;
    en_modulator  = 1'b0;
    // A read is only issued when the word will actually be carried into the encoder.
    rd_en_buff    = (state == S_FETCH) && !buff_empty && en;
    case (state)
      S_ENC_REQ: begin
        req_encoder = 1'b1;
        en_encoder  = 1'b1;
      end
      S_ENC_REL: en_encoder = 1'b1;
      S_MOD_REQ: begin
        req_modulator = 1'b1;
        en_modulator  = 1'b1;
      end
      S_MOD_REL: en_modulator = 1'b1;
      S_DONE:    ack = 1'b1;
      S_ERR: begin
        ack = 1'b1;
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fec_chain_sequencer.sv
// Directed bench for fec_chain_sequencer: a per-cycle vector table for one word's
// handshake walk plus hand-written frame, stall, timeout, abort and reset sequences.
module tb_fec_chain_sequencer;

  localparam int FL  = 8;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n, en, req, buff_empty;
  logic       ack, err, rd_en_buff;
  logic       req_encoder, ack_encoder, en_encoder;
  logic       req_modulator, ack_modulator, en_modulator;
  logic [3:0] words_done;

  logic enc_auto, enc_force, mod_auto, mod_force;
  int   checks = 0;
  int   errors = 0;

  fec_chain_sequencer #(.FRAME_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack), .err(err),
    .buff_empty(buff_empty), .rd_en_buff(rd_en_buff),
    .req_encoder(req_encoder), .ack_encoder(ack_encoder), .en_encoder(en_encoder),
    .req_modulator(req_modulator), .ack_modulator(ack_modulator), .en_modulator(en_modulator),
    .words_done(words_done)
  );

  always #5 clk = ~clk;

  // Zero-latency stage model: ack follows req unless a test overrides the level.
  always_comb begin
    ack_encoder   = enc_auto ? req_encoder : enc_force;
    ack_modulator = mod_auto ? req_modulator : mod_force;
  end

  logic [10:0] outv;
  assign outv = {ack, err, rd_en_buff, req_encoder, en_encoder, req_modulator, en_modulator, words_done};

  function automatic logic [10:0] o(input logic a, e, r, re, ee, rm, em, input int wd);
    logic [3:0] w;
    w = 4'(wd);
    return {a, e, r, re, ee, rm, em, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs cycles from the req-sampling edge (edge 0, after which cycle 1 begins) until
  // ack, recording per-cycle activity and applying scenario-specific disturbances.
  task automatic run_frame(input int scen, output int cyc, output int rd_cnt,
                           output int enc_cnt, output int mod_cnt, output bit alt_ok,
                           output int mark, output int wd_first);
    logic pe, pm;
    bit   last_enc;
    cyc = 0; rd_cnt = 0; enc_cnt = 0; mod_cnt = 0; alt_ok = 1'b1; mark = 0;
    wd_first = -1; pe = 1'b0; pm = 1'b0; last_enc = 1'b0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) wd_first = int'(words_done);
      if (scen == 4 && mark != 0 && cyc == mark + 1) break;
      if (ack) break;
      if (scen == 1 && cyc == 21) begin
        buff_empty = 1'b0;
        #1;
      end
      if (rd_en_buff) rd_cnt++;
      if (req_encoder && !pe) begin
        enc_cnt++;
        if (last_enc) alt_ok = 1'b0;
        last_enc = 1'b1;
        if (scen == 2 && enc_cnt == 3) begin
          enc_auto = 1'b0; enc_force = 1'b0; mark = cyc;
        end
        if (scen == 4 && enc_cnt == 5) begin
          en = 1'b0; mark = cyc;
        end
      end
      if (req_modulator && !pm) begin
        mod_cnt++;
        if (!last_enc) alt_ok = 1'b0;
        last_enc = 1'b0;
        if (scen == 3 && mod_cnt == 1) begin
          mod_auto = 1'b0; mod_force = 1'b1; mark = cyc;
        end
        if (scen == 5) begin
          mark = cyc;
          break;
        end
      end
      pe = req_encoder;
      pm = req_modulator;
    end
  endtask

  task automatic finish_frame(input string name);
    req = 1'b0;
    @(posedge clk); #1;
    chk({name, "_release_ack_err"}, {ack, err}, 2'b00);
    enc_auto = 1'b1; mod_auto = 1'b1;
    buff_empty = 1'b0; en = 1'b1;
  endtask

  typedef struct {
    logic        en, req, be, ae, am;
    logic        exp_rd_pre;
    logic [10:0] exp_out;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int cyc, rd_cnt, enc_cnt, mod_cnt, mark, wd_first;
    bit alt_ok;

    vecs[0]  = '{1, 1, 1, 0, 0, 0, o(0,0,0,0,0,0,0,0)};
    vecs[1]  = '{1, 1, 1, 0, 0, 0, o(0,0,0,0,0,0,0,0)};
    vecs[2]  = '{1, 1, 0, 0, 0, 1, o(0,0,0,1,1,0,0,0)};
    vecs[3]  = '{1, 1, 0, 0, 0, 0, o(0,0,0,1,1,0,0,0)};
    vecs[4]  = '{1, 1, 0, 1, 0, 0, o(0,0,0,0,1,0,0,0)};
    vecs[5]  = '{1, 1, 0, 1, 0, 0, o(0,0,0,0,1,0,0,0)};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, o(0,0,0,0,0,1,1,0)};
    vecs[7]  = '{1, 1, 0, 0, 1, 0, o(0,0,0,0,0,0,1,0)};
    vecs[8]  = '{1, 1, 0, 0, 0, 0, o(0,0,1,0,0,0,0,1)};
    vecs[9]  = '{1, 0, 0, 0, 0, 1, o(0,0,0,1,1,0,0,1)};
    vecs[10] = '{0, 0, 0, 1, 0, 0, o(0,0,0,0,0,0,0,1)};
    vecs[11] = '{0, 1, 0, 0, 0, 0, o(0,0,0,0,0,0,0,1)};
    vecs[12] = '{1, 1, 1, 0, 0, 0, o(0,0,0,0,0,0,0,0)};
    vecs[13] = '{0, 1, 1, 0, 0, 0, o(0,0,0,0,0,0,0,0)};

    rst_n = 1'b0; en = 1'b0; req = 1'b0; buff_empty = 1'b1;
    enc_auto = 1'b0; enc_force = 1'b0; mod_auto = 1'b0; mod_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outv, 11'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", outv, 11'd0);

    // Per-cycle walk with manually driven acks
    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; req = vecs[i].req; buff_empty = vecs[i].be;
      enc_force = vecs[i].ae; mod_force = vecs[i].am;
      #1;
      chk($sformatf("vec%0d_rd_pre", i), rd_en_buff, vecs[i].exp_rd_pre);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i), outv, vecs[i].exp_out);
    end
    req = 1'b0; en = 1'b1; buff_empty = 1'b0; enc_auto = 1'b1; mod_auto = 1'b1;
    @(posedge clk); #1;

    // Nominal frame
    req = 1'b1;
    run_frame(0, cyc, rd_cnt, enc_cnt, mod_cnt, alt_ok, mark, wd_first);
    chk("nom_ack_cycle", cyc, 41);
    chk("nom_err", err, 1'b0);
    chk("nom_words_done", words_done, 4'd8);
    chk("nom_rd_pulses", rd_cnt, 8);
    chk("nom_enc_hs", enc_cnt, 8);
    chk("nom_mod_hs", mod_cnt, 8);
    chk("nom_alternate", alt_ok, 1'b1);
    req = 1'b0;
    @(posedge clk); #1;
    chk("nom_idle_ack", {ack, err}, 2'b00);
    // One IDLE cycle between frames is the minimum gap
    req = 1'b1;
    @(posedge clk); #1;
    chk("b2b_fetch_rd", rd_en_buff, 1'b1);
    req = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;

    // Empty buffer stall for cycles 1-20
    buff_empty = 1'b1; req = 1'b1;
    run_frame(1, cyc, rd_cnt, enc_cnt, mod_cnt, alt_ok, mark, wd_first);
    chk("stall_ack_cycle", cyc, 61);
    chk("stall_err", err, 1'b0);
    chk("stall_rd_pulses", rd_cnt, 8);
    finish_frame("stall");

    // Encoder never acknowledges word 3
    req = 1'b1;
    run_frame(2, cyc, rd_cnt, enc_cnt, mod_cnt, alt_ok, mark, wd_first);
    chk("enc_tmo_entry", mark, 12);
    chk("enc_tmo_latency", cyc - mark, TMO);
    chk("enc_tmo_ack_err", {ack, err}, 2'b11);
    chk("enc_tmo_words", words_done, 4'd2);
    chk("enc_tmo_req_en", {req_encoder, en_encoder}, 2'b00);
    finish_frame("enc_tmo");

    // Modulator ack stuck high from the first MOD_REQ
    req = 1'b1;
    run_frame(3, cyc, rd_cnt, enc_cnt, mod_cnt, alt_ok, mark, wd_first);
    chk("mod_stuck_latency", cyc - mark, TMO + 1);
    chk("mod_stuck_ack_err", {ack, err}, 2'b11);
    chk("mod_stuck_words", words_done, 4'd0);
    finish_frame("mod_stuck");

    // Abort during ENC_REQ of word 5, then a clean re-request
    req = 1'b1;
    run_frame(4, cyc, rd_cnt, enc_cnt, mod_cnt, alt_ok, mark, wd_first);
    chk("abort_cycle", cyc, mark + 1);
    chk("abort_outputs", outv, o(0,0,0,0,0,0,0,4));
    @(posedge clk); #1;
    chk("abort_stays_idle", outv, o(0,0,0,0,0,0,0,4));
    req = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    req = 1'b1;
    run_frame(0, cyc, rd_cnt, enc_cnt, mod_cnt, alt_ok, mark, wd_first);
    chk("rereq_words_cleared", wd_first, 0);
    chk("rereq_ack_cycle", cyc, 41);
    chk("rereq_words_done", words_done, 4'd8);
    finish_frame("rereq");

    // Asynchronous reset while in MOD_REQ
    req = 1'b1;
    run_frame(5, cyc, rd_cnt, enc_cnt, mod_cnt, alt_ok, mark, wd_first);
    chk("rst_reached_mod_req", {req_modulator, en_modulator}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", outv, 11'd0);
    req = 1'b0; en = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", outv, 11'd0);
    en = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_restart_rd", rd_en_buff, 1'b1);
    en = 1'b0; req = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
